// File: rtl/uart_rx_oversampler.sv
// uart_rx_oversampler: UART receive front end. Synchronises rxd, majority-votes a centred
// window of oversampled ticks per bit, and frames start/data/parity/stop into a parallel word
// with glitch rejection on the start bit, framing/parity flags and break-condition recovery.
module uart_rx_oversampler #(
  parameter int OVERSAMPLE  = 16,
  parameter int WIN_LOW     = 6,
  parameter int WIN_HIGH    = 9,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 enable,
  input  logic                 rxd,
  output logic                 bit_out,
  output logic                 bit_valid,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W   = $clog2(OVERSAMPLE);
  localparam int WIN_LEN = WIN_HIGH - WIN_LOW + 1;
  localparam int VOTE_W  = $clog2(WIN_HIGH - WIN_LOW + 2);
  localparam int IDX_W   = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0]  LAST_SAMPLE = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0]  WIN_FIRST   = CNT_W'(WIN_LOW);
  localparam logic [CNT_W-1:0]  WIN_LAST    = CNT_W'(WIN_HIGH);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(DATA_BITS - 1);
  localparam logic [VOTE_W:0]   WIN_LEN_V   = (VOTE_W + 1)'(WIN_LEN);
  localparam logic              PAR_EN      = (PARITY_EN != 0);
  localparam logic              PAR_ODD     = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;

  logic [CNT_W-1:0]     sample_cnt, sample_cnt_d;
  logic [VOTE_W-1:0]    ones_cnt, ones_cnt_d;
  logic [VOTE_W-1:0]    ones_upd;
  logic [IDX_W-1:0]     bit_idx, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_bad, parity_bad_d;

  logic                 in_window;
  logic                 end_of_bit;
  logic                 vote;

  logic                 bit_out_d;
  logic                 bit_valid_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 data_valid_d;
  logic                 parity_err_d;
  logic                 frame_err_d;

  // Metastability synchroniser for the asynchronous line; idles high like the line itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
    end
  end

  assign rxd_s = sync_q[SYNC_STAGES-1];

  // The vote includes the current sample, so a window ending on the last tick still counts it.
  assign in_window  = (sample_cnt >= WIN_FIRST) && (sample_cnt <= WIN_LAST);
  assign ones_upd   = ones_cnt + VOTE_W'(in_window && rxd_s);
  assign vote       = {ones_upd, 1'b0} > WIN_LEN_V;
  assign end_of_bit = (sample_cnt == LAST_SAMPLE);

  assign busy = (state_q != IDLE);

  // Next-state, counter and registered-output decode; everything advances only on tick.
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt;
    ones_cnt_d   = ones_cnt;
    bit_idx_d    = bit_idx;
    shift_d      = shift_q;
    parity_bad_d = parity_bad;
    bit_out_d    = bit_out;
    bit_valid_d  = 1'b0;
    data_d       = data;
    data_valid_d = 1'b0;
    parity_err_d = parity_err;
    frame_err_d  = frame_err;

    if (!enable) begin
      state_d      = IDLE;
      sample_cnt_d = '0;
      ones_cnt_d   = '0;
      bit_idx_d    = '0;
    end else if (tick) begin
      case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            state_d      = START;
            sample_cnt_d = CNT_W'(1);
            ones_cnt_d   = '0;
          end
        end

        BREAK: begin
          if (rxd_s) begin
            state_d      = IDLE;
            sample_cnt_d = '0;
            ones_cnt_d   = '0;
          end
        end

        START, DATA, PARITY, STOP: begin
          sample_cnt_d = sample_cnt + 1'b1;
          if (!end_of_bit) begin
            ones_cnt_d = ones_upd;
          end else begin
            ones_cnt_d = '0;
            case (state_q)
              START: begin
                if (vote) begin
                  state_d = IDLE;
                end else begin
                  state_d     = DATA;
                  bit_idx_d   = '0;
                  bit_out_d   = 1'b0;
                  bit_valid_d = 1'b1;
                end
              end

              DATA: begin
                shift_d[bit_idx] = vote;
                bit_out_d        = vote;
                bit_valid_d      = 1'b1;
                if (bit_idx == LAST_IDX) begin
                  state_d = PAR_EN ? PARITY : STOP;
                end else begin
                  bit_idx_d = bit_idx + 1'b1;
                end
              end

              PARITY: begin
                parity_bad_d = (^shift_q) ^ vote ^ PAR_ODD;
                bit_out_d    = vote;
                bit_valid_d  = 1'b1;
                state_d      = STOP;
              end

              default: begin
                data_d       = shift_q;
                data_valid_d = 1'b1;
                frame_err_d  = ~vote;
                parity_err_d = PAR_EN & parity_bad;
                bit_out_d    = vote;
                bit_valid_d  = 1'b1;
                state_d      = vote ? IDLE : BREAK;
              end
            endcase
          end
        end

        default: begin
          state_d      = IDLE;
          sample_cnt_d = '0;
          ones_cnt_d   = '0;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, shift register and registered outputs; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt <= '0;
      ones_cnt   <= '0;
      bit_idx    <= '0;
      shift_q    <= '0;
      parity_bad <= 1'b0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sample_cnt <= sample_cnt_d;
      ones_cnt   <= ones_cnt_d;
      bit_idx    <= bit_idx_d;
      shift_q    <= shift_d;
      parity_bad <= parity_bad_d;
      bit_out    <= bit_out_d;
      bit_valid  <= bit_valid_d;
      data       <= data_d;
      data_valid <= data_valid_d;
      parity_err <= parity_err_d;
      frame_err  <= frame_err_d;
    end
  end

endmodule
